cache_ctrl_fsm: RTL and testbench
=================================

CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter ADDRESS_WORD_SIZE, default 32, address width in bits.
REQ-002 The block SHALL have parameter BLOCK_SIZE, default 8, bytes per cache line.
REQ-003 The block SHALL have parameter WORD_SIZE, default 8, data width in bits.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_b, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port cpu_req, input, 1, CPU access request, held until cpu_ready.
REQ-007 The block SHALL have port cpu_we, input, 1, 1 = write, 0 = read; sampled with cpu_req.
REQ-008 The block SHALL have port cpu_addr, input, ADDRESS_WORD_SIZE, byte address.
REQ-009 The block SHALL have port cpu_wdata, input, WORD_SIZE, write data.
REQ-010 The block SHALL have port cpu_rdata, output, WORD_SIZE, read data, valid while cpu_ready=1.
REQ-011 The block SHALL have port cpu_ready, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have ports set_addr (output, ADDRESS_WORD_SIZE), try_read, try_write, cache_write (outputs, 1) and set_wdata (output, WORD_SIZE), which drive the four-way set.
REQ-013 The block SHALL have ports hit_miss (input, 1), hit_index (input, 2), dirty_out (input, 1), valid_out (input, 1) and set_data (input, WORD_SIZE), returned by the set.
REQ-014 The block SHALL have port victim_way, output, 2, the way selected for refill.
REQ-015 The block SHALL have ports mem_req, mem_we (outputs, 1), mem_addr (output, ADDRESS_WORD_SIZE), mem_wdata (output, WORD_SIZE), mem_rdata (input, WORD_SIZE) and mem_ack (input, 1), forming the main-memory byte handshake.

Function
REQ-016 The FSM SHALL have states IDLE, LOOKUP, WRITEBACK, REFILL and RESPOND, encoded in 3 bits.
REQ-017 In IDLE, cpu_req=1 SHALL latch cpu_we, cpu_addr and cpu_wdata and move to LOOKUP on the next edge; these latches are not updated again until IDLE is re-entered.
REQ-018 In LOOKUP, the block SHALL assert try_read (read) or try_write (write) with set_addr = latched address for exactly one cycle.
REQ-019 On a LOOKUP hit on a read, the block SHALL capture set_data and go to RESPOND.
REQ-020 On a LOOKUP hit on a write, the block SHALL pulse cache_write with set_wdata = latched data in the same cycle and go to RESPOND.
REQ-021 On a LOOKUP miss, the block SHALL go to WRITEBACK if the victim has valid=1 and dirty=1, and to REFILL otherwise.
REQ-022 WRITEBACK and REFILL SHALL each transfer BLOCK_SIZE bytes. Each byte uses mem_req=1 held until mem_ack=1, with mem_addr = line base (latched address with its low log2(BLOCK_SIZE) bits cleared) + beat; mem_we=1 in WRITEBACK and mem_we=0 in REFILL.
REQ-023 The beat counter SHALL be log2(BLOCK_SIZE)+1 bits wide, increment only on mem_ack, and clear on each state entry. The last beat (beat = BLOCK_SIZE-1) SHALL move WRITEBACK to REFILL and REFILL to LOOKUP.
REQ-024 After REFILL, the LOOKUP retry SHALL hit; a second consecutive miss SHALL go to IDLE without asserting cpu_ready. This second miss is an error case and is flagged by verification.
REQ-025 victim_way SHALL come from a 2-bit round-robin counter that increments by 1 (3 wraps to 0) at each REFILL exit.
REQ-026 RESPOND SHALL assert cpu_ready for exactly one cycle, drive cpu_rdata with the captured byte (writes: latched data), then return to IDLE.
REQ-027 A cpu_req held high through RESPOND SHALL be treated as a new request in the following IDLE cycle. Minimum hit latency is cpu_req at edge N to cpu_ready during cycle N+2.
REQ-028 mem_ack when mem_req=0 SHALL be ignored.
REQ-029 All set and memory strobes SHALL be 0 outside the states named above.

Reset
REQ-030 rst_b=0 SHALL immediately force state IDLE and set beat = 0, victim_way = 0, all strobes = 0, cpu_ready = 0 and cpu_rdata = 0, mem_addr = 0, set_addr = 0, including mid-WRITEBACK or mid-REFILL.
REQ-031 After reset release, the first edge SHALL evaluate IDLE normally.

Configuration
REQ-032 With macro CACHE_CTRL_STATS_EN defined, the block SHALL add 16-bit outputs hit_count and miss_count. They reset to 0, increment on the first LOOKUP of each request (hit or miss respectively) and saturate at 16'hFFFF.
REQ-033 Without CACHE_CTRL_STATS_EN, those ports and counters SHALL NOT exist.

Verification
REQ-034 Read hit: set returns hit_miss=1, set_data=8'hA5 -> cpu_ready pulse 2 cycles after cpu_req, cpu_rdata=8'hA5.
REQ-035 Write hit: cpu_addr=32'h40, cpu_wdata=8'h3C -> one cache_write pulse, set_wdata=8'h3C, cpu_ready one cycle later.
REQ-036 Clean miss, BLOCK_SIZE=8, cpu_addr=32'h1234 -> 8 reads at mem_addr 32'h1230..32'h1237, then a LOOKUP hit and cpu_ready.
REQ-037 Dirty miss -> 8 mem_we=1 beats, then 8 mem_we=0 beats, and victim_way advances 0->1.
REQ-038 rst_b pulsed low at beat 3 of REFILL -> state IDLE, mem_req=0, beat=0 immediately.
REQ-039 With CACHE_CTRL_STATS_EN defined: 3 hits and 1 miss -> hit_count=3 and miss_count=1.

Source files
------------

// File: rtl/cache_ctrl_fsm.sv
// Controller FSM between a CPU port, a four-way cache set and a byte-wide memory port.
// Optional hit/miss counters are built only when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl_fsm #(
  parameter int unsigned ADDRESS_WORD_SIZE = 32,
  parameter int unsigned BLOCK_SIZE        = 8,
  parameter int unsigned WORD_SIZE         = 8
) (
  input  logic                         clk,
  input  logic                         rst_b,
  // CPU side
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]         cpu_wdata,
  output logic [WORD_SIZE-1:0]         cpu_rdata,
  output logic                         cpu_ready,
  // Cache set side
  output logic [ADDRESS_WORD_SIZE-1:0] set_addr,
  output logic                         try_read,
  output logic                         try_write,
  output logic                         cache_write,
  output logic [WORD_SIZE-1:0]         set_wdata,
  input  logic                         hit_miss,
  input  logic [1:0]                   hit_index,
  input  logic                         dirty_out,
  input  logic                         valid_out,
  input  logic [WORD_SIZE-1:0]         set_data,
  output logic [1:0]                   victim_way,
  // Memory side
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]         mem_wdata,
  input  logic [WORD_SIZE-1:0]         mem_rdata,
  input  logic                         mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]                  hit_count,
  output logic [15:0]                  miss_count
`endif
);

  localparam int unsigned OffW  = $clog2(BLOCK_SIZE);
  localparam int unsigned BeatW = OffW + 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLookup    = 3'd1,
    StWriteback = 3'd2,
    StRefill    = 3'd3,
    StRespond   = 3'd4
  } state_e;

  state_e                         state_q;
  logic                           we_q;
  logic [ADDRESS_WORD_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0]           wdata_q;
  logic                           retry_q;
  logic [BeatW-1:0]               beat_q;

  logic [ADDRESS_WORD_SIZE-1:0]   line_base;
  logic [ADDRESS_WORD_SIZE-1:0]   next_addr;
  logic                           beat_done;
  logic                           last_beat;
  logic                           unused_ok;

  assign line_base = {addr_q[ADDRESS_WORD_SIZE-1:OffW], {OffW{1'b0}}};
  assign next_addr = line_base + ADDRESS_WORD_SIZE'(beat_q) + ADDRESS_WORD_SIZE'(1);
  assign beat_done = mem_req & mem_ack;
  assign last_beat = (beat_q == LastBeat);

  // The write must land in the set in the same cycle the hit is reported, so this strobe
  // is decoded from the registered state and the live hit flag rather than registered.
  assign cache_write = (state_q == StLookup) & we_q & hit_miss;

  // Victim bytes stream straight from the set during writeback.
  assign mem_wdata = (state_q == StWriteback) ? set_data : '0;

  // Refill data and the hit way are consumed by the set itself, not by this controller.
  assign unused_ok = ^{mem_rdata, hit_index};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      retry_q    <= 1'b0;
      beat_q     <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      set_addr   <= '0;
      set_wdata  <= '0;
      try_read   <= 1'b0;
      try_write  <= 1'b0;
      victim_way <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
`ifdef CACHE_CTRL_STATS_EN
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          retry_q <= 1'b0;
          if (cpu_req) begin
            we_q      <= cpu_we;
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            set_addr  <= cpu_addr;
            set_wdata <= cpu_wdata;
            try_read  <= ~cpu_we;
            try_write <= cpu_we;
            state_q   <= StLookup;
          end
        end

        StLookup: begin
          try_read  <= 1'b0;
          try_write <= 1'b0;
`ifdef CACHE_CTRL_STATS_EN
          // Only the first probe of a request is counted; the post-refill retry is not.
          if (!retry_q) begin
            if (hit_miss) begin
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
          end
`endif
          if (hit_miss) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= we_q ? wdata_q : set_data;
            state_q   <= StRespond;
          end else if (retry_q) begin
            // Refill did not produce a hit: abandon the request without a response.
            state_q <= StIdle;
          end else begin
            beat_q   <= '0;
            mem_req  <= 1'b1;
            mem_addr <= line_base;
            if (valid_out && dirty_out) begin
              mem_we  <= 1'b1;
              state_q <= StWriteback;
            end else begin
              mem_we  <= 1'b0;
              state_q <= StRefill;
            end
          end
        end

        StWriteback: begin
          if (beat_done) begin
            if (last_beat) begin
              beat_q   <= '0;
              mem_addr <= line_base;
              mem_we   <= 1'b0;
              state_q  <= StRefill;
            end else begin
              beat_q   <= beat_q + 1'b1;
              mem_addr <= next_addr;
            end
          end
        end

        StRefill: begin
          if (beat_done) begin
            if (last_beat) begin
              beat_q     <= '0;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              victim_way <= victim_way + 2'd1;
              retry_q    <= 1'b1;
              try_read   <= ~we_q;
              try_write  <= we_q;
              state_q    <= StLookup;
            end else begin
              beat_q   <= beat_q + 1'b1;
              mem_addr <= next_addr;
            end
          end
        end

        StRespond: begin
          cpu_ready <= 1'b0;
          state_q   <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed self-checking bench for cache_ctrl_fsm with a simple acking memory responder.
// Define CACHE_CTRL_STATS_EN to also exercise the hit/miss counters.
module tb_cache_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic [31:0] set_addr;
  logic        try_read, try_write, cache_write;
  logic [7:0]  set_wdata;
  logic        hit_miss;
  logic [1:0]  hit_index;
  logic        dirty_out, valid_out;
  logic [7:0]  set_data;
  logic [1:0]  victim_way;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        ack_model, ack_stray;
  logic        mem_ack;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int total;
  int bad;

  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [7:0]  log_wd[$];

  assign mem_ack = ack_model | ack_stray;

  always #5 clk = ~clk;

  cache_ctrl_fsm dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .set_addr    (set_addr),
    .try_read    (try_read),
    .try_write   (try_write),
    .cache_write (cache_write),
    .set_wdata   (set_wdata),
    .hit_miss    (hit_miss),
    .hit_index   (hit_index),
    .dirty_out   (dirty_out),
    .valid_out   (valid_out),
    .set_data    (set_data),
    .victim_way  (victim_way),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  // Memory responder: one-cycle ack for each pending byte, logging what was presented.
  initial begin
    ack_model = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_model) begin
        ack_model = 1'b0;
      end else if (mem_req && rst_b) begin
        ack_model = 1'b1;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_wd.push_back(mem_wdata);
      end
    end
  end

  task automatic log_clear();
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    #3;
    total++;
    if ({cpu_ready, try_read, try_write, cache_write, mem_req, mem_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=000000",
               {cpu_ready, try_read, try_write, cache_write, mem_req, mem_we});
    end
    total++;
    if (cpu_rdata !== 8'h00 || mem_addr !== 32'h0 || set_addr !== 32'h0 || victim_way !== 2'd0)
    begin
      bad++;
      $display("FAIL reset_values rdata=%h mem_addr=%h set_addr=%h victim=%0d want all 0",
               cpu_rdata, mem_addr, set_addr, victim_way);
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    total++;
    if (dut.state_q !== 3'd0 || try_read !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle state=%0d try_read=%b want 0 0", dut.state_q, try_read);
    end
  endtask

  task automatic test_read_hit();
    @(negedge clk);
    hit_miss = 1'b1; set_data = 8'hA5; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    @(negedge clk);
    total++;
    if (try_read !== 1'b1 || try_write !== 1'b0 || set_addr !== 32'h10 || cpu_ready !== 1'b0)
    begin
      bad++;
      $display("FAIL read_hit_lookup rd=%b wr=%b addr=%h rdy=%b want 1 0 00000010 0",
               try_read, try_write, set_addr, cpu_ready);
    end
    cpu_addr = 32'hFFFF_0000;
    @(negedge clk);
    total++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL read_hit_respond rdy=%b rdata=%h want 1 a5", cpu_ready, cpu_rdata);
    end
    total++;
    if (try_read !== 1'b0) begin
      bad++;
      $display("FAIL read_hit_try_once try_read=%b want 0", try_read);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    total++;
    if (cpu_ready !== 1'b0 || set_addr !== 32'h10) begin
      bad++;
      $display("FAIL read_hit_done rdy=%b set_addr=%h want 0 00000010", cpu_ready, set_addr);
    end
    hit_miss = 1'b0;
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    hit_miss = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    @(negedge clk);
    total++;
    if (cache_write !== 1'b1 || set_wdata !== 8'h3C || try_write !== 1'b1 || cpu_ready !== 1'b0)
    begin
      bad++;
      $display("FAIL write_hit_lookup cw=%b wdata=%h tw=%b rdy=%b want 1 3c 1 0",
               cache_write, set_wdata, try_write, cpu_ready);
    end
    @(negedge clk);
    total++;
    if (cache_write !== 1'b0 || cpu_ready !== 1'b1 || cpu_rdata !== 8'h3C) begin
      bad++;
      $display("FAIL write_hit_respond cw=%b rdy=%b rdata=%h want 0 1 3c",
               cache_write, cpu_ready, cpu_rdata);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    hit_miss = 1'b0;
  endtask

  task automatic test_dirty_miss();
    int rdy;
    log_clear();
    @(negedge clk);
    hit_miss = 1'b0; valid_out = 1'b1; dirty_out = 1'b1; set_data = 8'h77;
    cpu_we = 1'b0; cpu_addr = 32'h8B; cpu_req = 1'b1;
    rdy = 0;
    for (int i = 0; i < 120 && rdy == 0; i++) begin
      @(negedge clk);
      if (try_read && log_addr.size() == 16) hit_miss = 1'b1;
      if (cpu_ready) begin
        rdy = 1;
        cpu_req = 1'b0;
      end
    end
    total++;
    if (rdy != 1 || log_addr.size() != 16) begin
      bad++;
      $display("FAIL dirty_miss_done ready=%0d beats=%0d want 1 16", rdy, log_addr.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (log_addr[i] !== 32'h88 + 32'(i % 8) || log_we[i] !== (i < 8)) begin
          bad++;
          $display("FAIL dirty_miss_beat%0d addr=%h we=%b want %h %b", i, log_addr[i],
                   log_we[i], 32'h88 + 32'(i % 8), (i < 8));
        end
      end
      total++;
      if (log_wd[0] !== 8'h77) begin
        bad++;
        $display("FAIL dirty_miss_wdata got=%h want 77", log_wd[0]);
      end
    end
    total++;
    if (victim_way !== 2'd1) begin
      bad++;
      $display("FAIL dirty_miss_victim got=%0d want 1", victim_way);
    end
    @(negedge clk);
    hit_miss = 1'b0; valid_out = 1'b0; dirty_out = 1'b0;
  endtask

  task automatic test_clean_miss(input logic [31:0] addr, input logic [1:0] exp_victim,
                                 input logic [7:0] data);
    int rdy;
    logic [7:0]  rd;
    logic [31:0] base;
    base = {addr[31:3], 3'b000};
    rd = 8'h00;
    log_clear();
    @(negedge clk);
    hit_miss = 1'b0; valid_out = 1'b0; dirty_out = 1'b0; set_data = data;
    cpu_we = 1'b0; cpu_addr = addr; cpu_req = 1'b1;
    rdy = 0;
    for (int i = 0; i < 80 && rdy == 0; i++) begin
      @(negedge clk);
      if (try_read && log_addr.size() == 8) hit_miss = 1'b1;
      if (cpu_ready) begin
        rdy = 1;
        rd = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    total++;
    if (rdy != 1 || rd !== data || log_addr.size() != 8) begin
      bad++;
      $display("FAIL clean_miss_done ready=%0d rdata=%h beats=%0d want 1 %h 8", rdy, rd,
               log_addr.size(), data);
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (log_addr[i] !== base + 32'(i) || log_we[i] !== 1'b0) begin
          bad++;
          $display("FAIL clean_miss_beat%0d addr=%h we=%b want %h 0", i, log_addr[i],
                   log_we[i], base + 32'(i));
        end
      end
    end
    total++;
    if (victim_way !== exp_victim) begin
      bad++;
      $display("FAIL clean_miss_victim got=%0d want %0d", victim_way, exp_victim);
    end
    @(negedge clk);
    hit_miss = 1'b0;
  endtask

  task automatic test_double_miss();
    int rdy;
    log_clear();
    @(negedge clk);
    hit_miss = 1'b0; valid_out = 1'b0; dirty_out = 1'b0;
    cpu_we = 1'b0; cpu_addr = 32'h300; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ready) rdy++;
    end
    total++;
    if (rdy != 0 || log_addr.size() != 8) begin
      bad++;
      $display("FAIL double_miss_no_ready readies=%0d beats=%0d want 0 8", rdy, log_addr.size());
    end
    total++;
    if (dut.state_q !== 3'd0 || mem_req !== 1'b0 || victim_way !== 2'd3) begin
      bad++;
      $display("FAIL double_miss_idle state=%0d mem_req=%b victim=%0d want 0 0 3",
               dut.state_q, mem_req, victim_way);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    logic [7:0] got1, got2;
    got1 = 8'h00; got2 = 8'h00;
    @(negedge clk);
    hit_miss = 1'b1; set_data = 8'h11; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = cpu_ready;
      if (i == 1) begin
        got1 = cpu_rdata;
        set_data = 8'h22;
      end
      if (i == 4) begin
        got2 = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    total++;
    if (pat !== 6'b010010) begin
      bad++;
      $display("FAIL back_to_back_ready pattern=%b want 010010", pat);
    end
    total++;
    if (got1 !== 8'h11 || got2 !== 8'h22) begin
      bad++;
      $display("FAIL back_to_back_data got=%h %h want 11 22", got1, got2);
    end
    hit_miss = 1'b0;
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    ack_stray = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || dut.state_q !== 3'd0 || dut.beat_q !== 4'd0) begin
      bad++;
      $display("FAIL stray_ack mem_req=%b state=%0d beat=%0d want 0 0 0", mem_req, dut.state_q,
               dut.beat_q);
    end
    ack_stray = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    int found;
    log_clear();
    @(negedge clk);
    hit_miss = 1'b0; valid_out = 1'b0; dirty_out = 1'b0;
    cpu_we = 1'b0; cpu_addr = 32'h200; cpu_req = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(posedge clk);
      #2;
      if (dut.state_q == 3'd3 && dut.beat_q == 4'd3) found = 1;
    end
    total++;
    if (found != 1) begin
      bad++;
      $display("FAIL reset_mid_refill_reach beat3 seen=%0d want 1", found);
    end
    cpu_req = 1'b0;
    rst_b = 1'b0;
    #1;
    total++;
    if (dut.state_q !== 3'd0 || dut.beat_q !== 4'd0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_refill state=%0d beat=%0d mem_req=%b want 0 0 0", dut.state_q,
               dut.beat_q, mem_req);
    end
    total++;
    if (victim_way !== 2'd0 || mem_addr !== 32'h0 || set_addr !== 32'h0 || cpu_ready !== 1'b0)
    begin
      bad++;
      $display("FAIL reset_mid_refill_regs victim=%0d mem_addr=%h set_addr=%h rdy=%b want 0",
               victim_way, mem_addr, set_addr, cpu_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

`ifdef CACHE_CTRL_STATS_EN
  task automatic test_stats();
    int rdy;
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      hit_miss = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; cpu_req = 1'b1;
      rdy = 0;
      for (int i = 0; i < 10 && rdy == 0; i++) begin
        @(negedge clk);
        if (cpu_ready) begin
          rdy = 1;
          cpu_req = 1'b0;
        end
      end
    end
    log_clear();
    @(negedge clk);
    hit_miss = 1'b0; valid_out = 1'b0; dirty_out = 1'b0; cpu_addr = 32'h60; cpu_req = 1'b1;
    rdy = 0;
    for (int i = 0; i < 80 && rdy == 0; i++) begin
      @(negedge clk);
      if (try_read && log_addr.size() == 8) hit_miss = 1'b1;
      if (cpu_ready) begin
        rdy = 1;
        cpu_req = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (hit_count !== 16'd3 || miss_count !== 16'd1) begin
      bad++;
      $display("FAIL stats hit=%0d miss=%0d want 3 1", hit_count, miss_count);
    end
    hit_miss = 1'b0;
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 8'h00;
    hit_miss = 1'b0; hit_index = 2'd0; dirty_out = 1'b0; valid_out = 1'b0;
    set_data = 8'h00; mem_rdata = 8'h00; ack_stray = 1'b0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_clean_miss(32'h1234, 2'd2, 8'h5A);
    test_double_miss();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid_refill();
    test_clean_miss(32'h1234, 2'd1, 8'hC3);
`ifdef CACHE_CTRL_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
